axi_ram_bridge: RTL

AXI_RAM_BRIDGE -- requirements
Module: axi_ram_bridge

---
 rtl/axi_ram_bridge.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/axi_ram_bridge.sv
// AXI4 (INCR-only, 64-bit) slave to single-port synchronous-write / combinational-read RAM bridge.
// One burst outstanding; round-robin arbitration between write and read address channels.
`timescale 1ns/1ps
module axi_ram_bridge (
  input  logic        cpu_clk_50M,
  input  logic        rst_n,
  input  logic        aw_valid,
  output logic        aw_ready,
  input  logic [63:0] aw_addr,
  input  logic [7:0]  aw_len,
  input  logic        w_valid,
  output logic        w_ready,
  input  logic [63:0] w_data,
  input  logic [7:0]  w_strb,
  input  logic        w_last,
  output logic        b_valid,
  input  logic        b_ready,
  output logic [1:0]  b_resp,
  input  logic        ar_valid,
  output logic        ar_ready,
  input  logic [63:0] ar_addr,
  input  logic [7:0]  ar_len,
  output logic        r_valid,
  input  logic        r_ready,
  output logic [63:0] r_data,
  output logic        r_last,
  output logic        ram_wr_en,
  output logic        ram_rd_en,
  output logic [63:0] ram_wmask,
  output logic [63:0] ram_addr,
  output logic [63:0] ram_wr_data,
  input  logic [63:0] ram_rd_data
);

  // state | meaning
  // IDLE  | waiting for AW or AR, arbitration active
  // WRITE | accepting W beats, one RAM write per beat
  // WRESP | holding b_valid until b_ready
  // READ  | issuing RAM reads into the registered R beat
  typedef enum logic [1:0] {IDLE, WRITE, WRESP, READ} state_t;

  state_t      state;
  logic [63:0] beat_addr;
  logic [7:0]  beat_cnt;
  logic [7:0]  len_q;
  logic        rd_granted_last;
  logic        wr_err;
  logic        rd_all_issued;
  logic        grant_w;
  logic        grant_r;
  logic        w_hs;
  logic        rd_issue;
  logic        final_beat;
  logic        unused_addr_lsb;

  assign unused_addr_lsb = ^{aw_addr[2:0], ar_addr[2:0]};

  always_comb begin
    grant_w = aw_valid && (!ar_valid || rd_granted_last);
    grant_r = ar_valid && (!aw_valid || !rd_granted_last);
  end

  assign aw_ready    = (state == IDLE) && grant_w;
  assign ar_ready    = (state == IDLE) && grant_r;
  assign w_ready     = (state == WRITE);
  assign w_hs        = w_ready && w_valid;
  assign final_beat  = (beat_cnt == len_q);
  // A new read is only launched when the output register is free or draining this cycle.
  assign rd_issue    = (state == READ) && !rd_all_issued && (!r_valid || r_ready);
  assign ram_wr_en   = w_hs;
  assign ram_rd_en   = rd_issue;
  assign ram_addr    = beat_addr;
  assign ram_wr_data = w_data;

  always_comb begin
    ram_wmask = '0;
    for (int i = 0; i < 8; i++) begin
      ram_wmask[8*i +: 8] = {8{w_strb[i]}};
    end
  end

  always_ff @(posedge cpu_clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      beat_addr       <= '0;
      beat_cnt        <= '0;
      len_q           <= '0;
      rd_granted_last <= 1'b1;
      wr_err          <= 1'b0;
      rd_all_issued   <= 1'b0;
      b_valid         <= 1'b0;
      b_resp          <= 2'b00;
      r_valid         <= 1'b0;
      r_data          <= '0;
      r_last          <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (aw_ready) begin
            beat_addr       <= {aw_addr[63:3], 3'b000};
            beat_cnt        <= '0;
            len_q           <= aw_len;
            wr_err          <= 1'b0;
            rd_granted_last <= 1'b0;
            state           <= WRITE;
          end else if (ar_ready) begin
            beat_addr       <= {ar_addr[63:3], 3'b000};
            beat_cnt        <= '0;
            len_q           <= ar_len;
            rd_all_issued   <= 1'b0;
            rd_granted_last <= 1'b1;
            state           <= READ;
          end
        end
        WRITE: begin
          if (w_hs) begin
            beat_addr <= beat_addr + 64'd8;
            beat_cnt  <= beat_cnt + 8'd1;
            // Burst length comes from aw_len; a misplaced w_last only flags SLVERR.
            if (final_beat) begin
              b_valid <= 1'b1;
              b_resp  <= (wr_err || !w_last) ? 2'b10 : 2'b00;
              state   <= WRESP;
            end else if (w_last) begin
              wr_err <= 1'b1;
            end
          end
        end
        WRESP: begin
          if (b_ready) begin
            b_valid <= 1'b0;
            state   <= IDLE;
          end
        end
        READ: begin
          if (rd_issue) begin
            r_data    <= ram_rd_data;
            r_valid   <= 1'b1;
            r_last    <= final_beat;
            beat_addr <= beat_addr + 64'd8;
            beat_cnt  <= beat_cnt + 8'd1;
            if (final_beat) rd_all_issued <= 1'b1;
          end else if (r_valid && r_ready) begin
            r_valid <= 1'b0;
            if (r_last) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
